// File: rtl/rgmii_pkg.sv
// Shared types and helpers for the Ethernet TX path: arbiter FSM states and
// the round-robin pick function used by rr_arbiter.
package rgmii_pkg;

  localparam int unsigned MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // First set request strictly after 'last', wrapping within n channels.
  function automatic logic [MAX_CH-1:0] rr_pick(
    input logic [MAX_CH-1:0] req,
    input logic [2:0]        last,
    input int unsigned       n
  );
    logic [MAX_CH-1:0] pick;
    logic              found;
    logic [2:0]        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = 3'((32'(last) + i) % n);
      if ((i <= n) && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin picker: grants the first requester after the previous
// grant index, plus the encoded index of that grant.
module rr_arbiter
  import rgmii_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  last_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  output logic              any_o
);

  logic [MAX_CH-1:0] req_ext_s;
  logic [2:0]        last_ext_s;
  logic [MAX_CH-1:0] pick_s;

  // Widen to the package helper's fixed width and encode the pick.
  always_comb begin
    req_ext_s               = '0;
    req_ext_s[NUM_CH-1:0]   = req_i;
    last_ext_s              = 3'd0;
    last_ext_s[IDX_W-1:0]   = last_i;
    pick_s                  = rr_pick(req_ext_s, last_ext_s, NUM_CH);
    grant_o                 = pick_s[NUM_CH-1:0];
    any_o                   = |pick_s;
    grant_idx_o             = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pick_s[k]) begin
        grant_idx_o = IDX_W'(k);
      end else begin
        grant_idx_o = grant_idx_o;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_CH AXIS byte streams into one.
// Optional ETH_ARB_STATS_EN adds per-channel packet and length-error counters.
module eth_tx_arbiter
  import rgmii_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PAYLOAD_WIDTH = 11,
  parameter int unsigned GAP_CYCLES    = 64
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [NUM_CH*8-1:0]             s_tdata_i,
  input  logic [NUM_CH-1:0]               s_tvalid_i,
  input  logic [NUM_CH-1:0]               s_tlast_i,
  output logic [NUM_CH-1:0]               s_tready_o,
  input  logic [NUM_CH*PAYLOAD_WIDTH-1:0] ch_len_i,
  input  logic [NUM_CH*16-1:0]            ch_port_i,
  output logic [7:0]                      m_tdata_o,
  output logic                            m_tvalid_o,
  output logic                            m_tlast_o,
  input  logic                            m_tready_i,
  output logic [PAYLOAD_WIDTH-1:0]        payload_bytes_o,
  output logic [15:0]                     host_port_o,
  output logic [NUM_CH-1:0]               grant_o,
  output logic                            busy_o,
  output logic                            len_err_o
`ifdef ETH_ARB_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]            pkt_cnt_o,
  output logic [15:0]                     err_cnt_o
`endif
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = PAYLOAD_WIDTH + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  logic [1:0]               rst_sync_r;
  logic                     rst_n_s;
  arb_state_e               state_r, state_nx_s;
  logic [NUM_CH-1:0]        grant_r;
  logic [IDX_W-1:0]         last_grant_r;
  logic [NUM_CH-1:0]        elig_s;
  logic [NUM_CH-1:0]        arb_grant_s;
  logic [IDX_W-1:0]         arb_idx_s;
  logic                     arb_any_s;
  logic [CNT_W-1:0]         beat_cnt_r, beat_nx_s;
  logic [GAP_W-1:0]         gap_cnt_r;
  logic                     err_flag_r, err_now_s;
  logic                     sel_valid_s, sel_last_s, xfer_s, hs_s, take_s, gap_done_s;
  logic [7:0]               sel_data_s;
  logic [PAYLOAD_WIDTH-1:0] payload_r;
  logic [15:0]              host_r;
  logic                     len_err_r, busy_r;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rst_sync_r <= 2'b00;
    else         rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n_s = rst_sync_r[1];

  // Requesters with a zero configured length are never eligible.
  always_comb begin
    elig_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      elig_s[k] = s_tvalid_i[k] & (ch_len_i[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] != {PAYLOAD_WIDTH{1'b0}});
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req_i       (elig_s),
    .last_i      (last_grant_r),
    .grant_o     (arb_grant_s),
    .grant_idx_o (arb_idx_s),
    .any_o       (arb_any_s)
  );

  // Granted-channel mux and handshake; zero-latency pass-through in XFER.
  always_comb begin
    xfer_s      = (state_r == ST_XFER);
    sel_valid_s = |(s_tvalid_i & grant_r);
    sel_last_s  = |(s_tlast_i & grant_r);
    sel_data_s  = 8'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_data_s = sel_data_s | (s_tdata_i[k*8 +: 8] & {8{grant_r[k]}});
    end
    m_tvalid_o = xfer_s & sel_valid_s;
    m_tlast_o  = xfer_s & sel_last_s;
    m_tdata_o  = xfer_s ? sel_data_s : 8'd0;
    s_tready_o = xfer_s ? (grant_r & {NUM_CH{m_tready_i}}) : {NUM_CH{1'b0}};
    hs_s       = m_tvalid_o & m_tready_i;
    take_s     = (state_r == ST_IDLE) & arb_any_s;
    gap_done_s = (state_r == ST_GAP) & (gap_cnt_r == GAP_W'(GAP_CYCLES - 1));
    beat_nx_s  = (&beat_cnt_r) ? beat_cnt_r : beat_cnt_r + CNT_W'(1);
  end

  // One error per packet: early tlast, or length reached with no tlast yet.
  always_comb begin
    err_now_s = 1'b0;
    if (hs_s && !err_flag_r) begin
      if (sel_last_s) err_now_s = (beat_nx_s != {1'b0, payload_r});
      else            err_now_s = (beat_nx_s == {1'b0, payload_r});
    end else begin
      err_now_s = 1'b0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (arb_any_s)         state_nx_s = ST_XFER; else state_nx_s = ST_IDLE;
      ST_XFER: if (hs_s && sel_last_s) state_nx_s = ST_GAP;  else state_nx_s = ST_XFER;
      ST_GAP:  if (gap_done_s)        state_nx_s = ST_IDLE; else state_nx_s = ST_GAP;
      default:                        state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state, grant bookkeeping and latched channel configuration.
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= IDX_W'(NUM_CH - 1);
      payload_r    <= '0;
      host_r       <= 16'd0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      if (take_s) begin
        grant_r      <= arb_grant_s;
        last_grant_r <= arb_idx_s;
        payload_r    <= ch_len_i[arb_idx_s*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        host_r       <= ch_port_i[arb_idx_s*16 +: 16];
      end else if (gap_done_s) begin
        grant_r <= '0;
      end
    end
  end

  // Beat and gap counters plus the registered length-error pulse.
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      beat_cnt_r <= '0;
      gap_cnt_r  <= '0;
      err_flag_r <= 1'b0;
      len_err_r  <= 1'b0;
    end else begin
      len_err_r <= err_now_s;
      gap_cnt_r <= (state_r == ST_GAP) ? gap_cnt_r + GAP_W'(1) : GAP_W'(0);
      if (take_s) begin
        beat_cnt_r <= '0;
        err_flag_r <= 1'b0;
      end else if (hs_s) begin
        beat_cnt_r <= beat_nx_s;
        err_flag_r <= err_flag_r | err_now_s;
      end
    end
  end

  assign grant_o         = grant_r;
  assign busy_o          = busy_r;
  assign len_err_o       = len_err_r;
  assign payload_bytes_o = payload_r;
  assign host_port_o     = host_r;

`ifdef ETH_ARB_STATS_EN
  logic [NUM_CH*16-1:0] pkt_cnt_r;
  logic [15:0]          err_cnt_r;

  // Completed packets per channel (wrapping) and saturating error count.
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      pkt_cnt_r <= '0;
      err_cnt_r <= 16'd0;
    end else begin
      if (hs_s && sel_last_s) begin
        pkt_cnt_r[last_grant_r*16 +: 16] <= pkt_cnt_r[last_grant_r*16 +: 16] + 16'd1;
      end
      if (err_now_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_r;
  assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter (NUM_CH=4, PAYLOAD_WIDTH=11,
// GAP_CYCLES=64).
module tb_eth_tx_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast, s_tready;
  logic [43:0] ch_len;
  logic [63:0] ch_port;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [10:0] payload;
  logic [15:0] host;
  logic [3:0]  grant;
  logic        busy, len_err;
`ifdef ETH_ARB_STATS_EN
  logic [63:0] pkt_cnt;
  logic [15:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  eth_tx_arbiter #(.NUM_CH(4), .PAYLOAD_WIDTH(11), .GAP_CYCLES(64)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
    .ch_len_i(ch_len), .ch_port_i(ch_port),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
    .payload_bytes_o(payload), .host_port_o(host), .grant_o(grant), .busy_o(busy),
    .len_err_o(len_err)
`ifdef ETH_ARB_STATS_EN
    , .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt)
`endif
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_len(input int k, input logic [10:0] l, input logic [15:0] p);
    ch_len[k*11 +: 11]  = l;
    ch_port[k*16 +: 16] = p;
  endtask

  task automatic drive(input int k, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[k]       = v;
    s_tdata[k*8 +: 8] = d;
    s_tlast[k]        = l;
  endtask

  task automatic clear_inputs();
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; ch_len = '0; ch_port = '0; m_tready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn_i = 1'b0;
    repeat (2) step();
    rstn_i = 1'b1;
    repeat (4) step();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn_i = 1'b0;
    step();
    checks++;
    if ({grant, busy, len_err, m_tvalid, s_tready} !== 11'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b required=0", {grant, busy, len_err, m_tvalid, s_tready});
    end
    checks++;
    if ({payload, host} !== 27'd0) begin
      failures++; $display("FAIL reset_cfg got=%h required=0", {payload, host});
    end
    rstn_i = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_single();
    int n;
    set_len(1, 11'd4, 16'h1234);
    drive(1, 1'b1, 8'h10, 1'b0);
    step();
    checks++;
    if ({grant, payload, host, busy} !== {4'b0010, 11'd4, 16'h1234, 1'b1}) begin
      failures++; $display("FAIL single_grant got=%b/%0d/%h/%b required=0010/4/1234/1", grant, payload, host, busy);
    end
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, 8'(16 + b), (b == 3));
      #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tdata, s_tready} !== {1'b1, (b == 3), 8'(16 + b), 4'b0010}) begin
        failures++; $display("FAIL single_beat%0d got=%b/%b/%h/%b", b, m_tvalid, m_tlast, m_tdata, s_tready);
      end
      step();
    end
    drive(1, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({len_err, m_tvalid, s_tready, busy} !== 7'b0000001) begin
      failures++; $display("FAIL single_gap_state got=%b required=0000001", {len_err, m_tvalid, s_tready, busy});
    end
    wait_idle(n);
    checks++;
    if (n !== 64) begin
      failures++; $display("FAIL single_gap_len got=%0d required=64", n);
    end
    checks++;
    if ({grant, payload} !== {4'b0000, 11'd4}) begin
      failures++; $display("FAIL single_hold got=%b/%0d required=0000/4", grant, payload);
    end
    set_len(1, 11'd0, 16'h0000);
  endtask

  task automatic test_round_robin();
    logic [3:0] beat2;
    logic [3:0] prev_grant;
    logic [3:0] exp;
    int ng = 0;
    int last_rise = 0;
    int bad_ready = 0;
    int errs = 0;
    do_reset();
    for (int k = 0; k < 4; k++) set_len(k, 11'd2, 16'(k));
    beat2 = 4'b0000;
    prev_grant = 4'b0000;
    s_tvalid = 4'hF;
    for (int cyc = 0; cyc < 500 && ng < 5; cyc++) begin
      step();
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        exp = 4'b0001 << (ng % 4);
        checks++;
        if (grant !== exp) begin
          failures++; $display("FAIL rr_order%0d got=%b required=%b", ng, grant, exp);
        end
        if (ng > 0) begin
          checks++;
          if (cyc - last_rise !== 67) begin
            failures++; $display("FAIL rr_spacing%0d got=%0d required=67", ng, cyc - last_rise);
          end
        end
        last_rise = cyc;
        ng++;
      end
      prev_grant = grant;
      errs += int'(len_err);
      for (int k = 0; k < 4; k++) s_tdata[k*8 +: 8] = {4'(k), 3'd0, beat2[k]};
      s_tlast = beat2;
      #1;
      if ((s_tready & ~grant) != 4'b0000) bad_ready++;
      beat2 = beat2 ^ (s_tready & s_tvalid);
    end
    checks++;
    if (ng !== 5) begin
      failures++; $display("FAIL rr_count got=%0d required=5", ng);
    end
    checks++;
    if ({bad_ready, errs} !== {32'd0, 32'd0}) begin
      failures++; $display("FAIL rr_ready_err got=%0d/%0d required=0/0", bad_ready, errs);
    end
  endtask

  task automatic test_len_err();
    int n;
    int pulses = 0;
    do_reset();
    set_len(0, 11'd5, 16'h0500);
    drive(0, 1'b1, 8'hC0, 1'b0);
    step();
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL short_grant got=%b required=0001", grant);
    end
    for (int b = 0; b < 3; b++) begin
      drive(0, 1'b1, 8'(8'hC0 + b), (b == 2));
      step();
      pulses += int'(len_err);
    end
    checks++;
    if ({len_err, busy, m_tvalid} !== 3'b110) begin
      failures++; $display("FAIL short_pulse got=%b required=110", {len_err, busy, m_tvalid});
    end
    drive(0, 1'b0, 8'h00, 1'b0);
    step();
    pulses += int'(len_err);
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL short_single got=%0d required=1", pulses);
    end
    wait_idle(n);
    checks++;
    if (n !== 63) begin
      failures++; $display("FAIL short_gap got=%0d required=63", n);
    end
    set_len(0, 11'd0, 16'h0000);
    set_len(2, 11'd2, 16'h0202);
    drive(2, 1'b1, 8'hA0, 1'b0);
    step();
    checks++;
    if ({grant, payload} !== {4'b0100, 11'd2}) begin
      failures++; $display("FAIL long_grant got=%b/%0d required=0100/2", grant, payload);
    end
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      drive(2, 1'b1, 8'(8'hA0 + b), (b == 3));
      #1;
      checks++;
      if ({m_tvalid, m_tdata} !== {1'b1, 8'(8'hA0 + b)}) begin
        failures++; $display("FAIL long_beat%0d got=%b/%h", b, m_tvalid, m_tdata);
      end
      step();
      pulses += int'(len_err);
      checks++;
      if (len_err !== (b == 1)) begin
        failures++; $display("FAIL long_pulse_at%0d got=%b required=%b", b, len_err, (b == 1));
      end
    end
    drive(2, 1'b0, 8'h00, 1'b0);
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL long_single got=%0d required=1", pulses);
    end
    wait_idle(n);
    set_len(2, 11'd0, 16'h0000);
  endtask

  task automatic test_backpressure();
    int n;
    int idx = 0;
    int rcv = 0;
    int errs = 0;
    set_len(1, 11'd6, 16'hBEEF);
    drive(1, 1'b1, 8'h50, 1'b0);
    m_tready = 1'b1;
    step();
    checks++;
    if (grant !== 4'b0010) begin
      failures++; $display("FAIL bp_grant got=%b required=0010", grant);
    end
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      m_tready = (cyc % 2 == 0);
      drive(1, (idx < 6), 8'(8'h50 + idx), (idx == 5));
      #1;
      checks++;
      if (s_tready !== {2'b00, m_tready, 1'b0}) begin
        failures++; $display("FAIL bp_ready%0d got=%b required=%b", cyc, s_tready, {2'b00, m_tready, 1'b0});
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (m_tdata !== 8'(8'h50 + rcv)) begin
          failures++; $display("FAIL bp_data%0d got=%h required=%h", rcv, m_tdata, 8'(8'h50 + rcv));
        end
        rcv++;
      end
      if (s_tready[1]) idx++;
      step();
      errs += int'(len_err);
    end
    drive(1, 1'b0, 8'h00, 1'b0);
    m_tready = 1'b1;
    checks++;
    if ({rcv, errs} !== {32'd6, 32'd0}) begin
      failures++; $display("FAIL bp_total got=%0d/%0d required=6/0", rcv, errs);
    end
    wait_idle(n);
    set_len(1, 11'd0, 16'h0000);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_len(3, 11'd8, 16'h0303);
    drive(3, 1'b1, 8'h70, 1'b0);
    step();
    checks++;
    if (grant !== 4'b1000) begin
      failures++; $display("FAIL rmid_grant got=%b required=1000", grant);
    end
    for (int b = 0; b < 2; b++) begin
      drive(3, 1'b1, 8'(8'h70 + b), 1'b0);
      step();
    end
    drive(3, 1'b1, 8'h72, 1'b0);
    set_len(0, 11'd3, 16'h0101);
    drive(0, 1'b1, 8'h01, 1'b0);
    rstn_i = 1'b0;
    #1;
    checks++;
    if ({grant, busy, len_err, m_tvalid, m_tlast, s_tready, payload, host} !== 39'd0) begin
      failures++; $display("FAIL rmid_outputs got=%b/%b/%b/%b/%b/%b/%0d/%h", grant, busy, len_err, m_tvalid, m_tlast, s_tready, payload, host);
    end
    step();
    step();
    rstn_i = 1'b1;
    while (grant == 4'b0000 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL rmid_first got=%b required=0001", grant);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    drive(3, 1'b1, 8'h33, 1'b1);
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      checks++;
      if ({grant, s_tready, busy} !== 9'd0) begin
        failures++; $display("FAIL zlen_cyc%0d got=%b/%b/%b required=0", cyc, grant, s_tready, busy);
      end
    end
  endtask

  initial begin
    rstn_i = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_len_err();
    test_backpressure();
    test_reset_mid();
    test_zero_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameters: NUM_CH, default 4, requester count (2..8); PAYLOAD_WIDTH, default 11, payload length width; GAP_CYCLES, default 64, idle hold after each packet (>=1).
REQ-002 SHALL have ports: clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 rstn_i  in  1  reset; asynchronous, active-low.
REQ-004 s_tdata_i  in  NUM_CH*8  per-channel AXIS byte, channel k at [8k+7:8k].
REQ-005 s_tvalid_i / s_tlast_i  in  NUM_CH each  per-channel AXIS valid / last.
REQ-006 s_tready_o  out  NUM_CH  per-channel AXIS ready.
REQ-007 ch_len_i  in  NUM_CH*PAYLOAD_WIDTH  per-channel payload bytes per packet.
REQ-008 ch_port_i  in  NUM_CH*16  per-channel destination UDP port.
REQ-009 m_tdata_o / m_tvalid_o / m_tlast_o  out  8/1/1  AXIS toward the packet generator FIFO.
REQ-010 m_tready_i  in  1  downstream ready.
REQ-011 payload_bytes_o / host_port_o  out  PAYLOAD_WIDTH/16  config of the granted channel, held stable.
REQ-012 grant_o  out  NUM_CH  one-hot current grant; busy_o  out  1  high in XFER or GAP.
REQ-013 len_err_o  out  1  one-cycle pulse on packet length mismatch.

Function
REQ-014 SHALL implement FSM IDLE -> XFER -> GAP -> IDLE.
REQ-015 IDLE: eligible = s_tvalid_i & (ch_len != 0); if any eligible, grant the first eligible channel strictly after last_grant (round-robin, wrapping), latch its ch_len/ch_port into payload_bytes_o/host_port_o, and enter XFER next cycle.
REQ-016 Channels with ch_len == 0 SHALL never be granted; their s_tready_o stays 0.
REQ-017 XFER: m_tdata/m_tvalid/m_tlast SHALL combinationally mirror the granted channel; s_tready_o[grant] = m_tready_i; all other s_tready_o = 0; zero added latency.
REQ-018 Beat counter (PAYLOAD_WIDTH+1 bits) SHALL increment per m_tvalid&m_tready handshake, cleared on grant.
REQ-019 Handshake with tlast SHALL end the packet: move to GAP; pulse len_err_o the next cycle if beats-including-last != latched length.
REQ-020 Counter reaching latched length without tlast SHALL pulse len_err_o once and continue forwarding until tlast (no truncation).
REQ-021 GAP: hold GAP_CYCLES cycles with all s_tready_o = 0 and m_tvalid_o = 0, then IDLE; payload_bytes_o/host_port_o SHALL remain unchanged until the next grant.
REQ-022 last_grant SHALL update on grant; grant_o is zero in IDLE.
REQ-023 Requester dropping s_tvalid_i mid-packet SHALL not release the grant (packet-granular arbitration).

Reset
REQ-024 On rstn_i low, immediately: state IDLE, grant_o 0, last_grant = NUM_CH-1 (channel 0 first), counters 0, payload_bytes_o 0, host_port_o 0, len_err_o 0, busy_o 0.
REQ-025 Reset mid-packet SHALL abandon the packet; no tlast is generated; reset release is synchronised internally to clk_i.

Configuration
REQ-026 Macro ETH_ARB_STATS_EN: when defined, adds output pkt_cnt_o (NUM_CH*16), per-channel wrapping count of completed packets, and err_cnt_o (16), saturating len_err count, both reset to 0; when undefined these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-027 The arbiter FSM state enum and the round-robin helper function SHALL live in the shared rgmii_pkg.
REQ-028 One sub-module: rr_arbiter (one-hot round-robin pick given request vector and last grant), instantiated once.

Verification
REQ-029 Ch1 only, ch_len=4, 4 beats tlast on 4th, m_tready=1 -> grant_o=0010 one cycle after valid, 4 beats out, no len_err, payload_bytes_o=4.
REQ-030 All 4 channels valid continuously, ch_len=2 -> grants in order 0,1,2,3,0 with GAP_CYCLES idle between each.
REQ-031 Ch0 ch_len=5, tlast on beat 3 -> len_err_o single pulse, FSM to GAP; ch2 ch_len=2, tlast on beat 4 -> one pulse at beat 2, all 4 beats forwarded.
REQ-032 m_tready_i toggled 1/0 during a 6-byte packet -> no lost or duplicated bytes, non-granted s_tready_o stay 0.
REQ-033 rstn_i asserted at beat 3 of 8 -> outputs at reset values same cycle; after release channel 0 granted first.
REQ-034 ch_len=0 on ch3 with valid high, others idle -> no grant, s_tready_o[3]=0 indefinitely.
